// File: rtl/core_lbuf.sv
// Per-core local buffer: packs narrow gbus write beats into wide MAC-operand words
// held in a FIFO, and returns one registered word per accepted controller read.
module core_lbuf #(
    parameter int WR_WIDTH = 64,
    parameter int RATIO    = 4,
    parameter int DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          wen,
    input  logic [WR_WIDTH-1:0]           wdata,
    input  logic                          ren,
    output logic [WR_WIDTH*RATIO-1:0]     rdata,
    output logic                          rvalid,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          wr_overflow,
    output logic                          rd_underflow
);

    localparam int RD_WIDTH = WR_WIDTH * RATIO;
    localparam int SUB_W    = $clog2(RATIO);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = $clog2(DEPTH + 1);

    logic [RD_WIDTH-1:0] mem_q [DEPTH];

    logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
    logic [RD_WIDTH-1:0] stage_q, stage_d, stage_w;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic [RD_WIDTH-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                wr_ovf_q, wr_ovf_d;
    logic                rd_unf_q, rd_unf_d;

    logic wr_acc, rd_acc, push, mem_we;

    always_comb begin
        wr_acc = wen && !full_q;
        rd_acc = ren && !empty_q;
        push   = wr_acc && (sub_cnt_q == SUB_W'(RATIO - 1));

        // Staging copy with the current beat merged in; on the last beat this is the pushed word.
        stage_w = stage_q;
        for (int k = 0; k < RATIO; k++) begin
            if (wr_acc && (sub_cnt_q == SUB_W'(k))) begin
                stage_w[k*WR_WIDTH +: WR_WIDTH] = wdata;
            end
        end

        sub_cnt_d = sub_cnt_q;
        stage_d   = stage_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        wr_ovf_d  = wr_ovf_q;
        rd_unf_d  = rd_unf_q;
        mem_we    = 1'b0;

        if (clear) begin
            sub_cnt_d = '0;
            stage_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            level_d   = '0;
            rdata_d   = '0;
            wr_ovf_d  = 1'b0;
            rd_unf_d  = 1'b0;
        end else begin
            mem_we  = push;
            stage_d = stage_w;
            if (wr_acc) begin
                sub_cnt_d = sub_cnt_q + SUB_W'(1);
            end
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rptr_d  = rptr_q + PTR_W'(1);
                rdata_d = mem_q[rptr_q];
            end
            rvalid_d = rd_acc;
            case ({push, rd_acc})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            wr_ovf_d = wr_ovf_q | (wen && full_q);
            rd_unf_d = rd_unf_q | (ren && empty_q);
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt_q <= '0;
            stage_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wr_ovf_q  <= 1'b0;
            rd_unf_q  <= 1'b0;
        end else begin
            sub_cnt_q <= sub_cnt_d;
            stage_q   <= stage_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            wr_ovf_q  <= wr_ovf_d;
            rd_unf_q  <= rd_unf_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked solely by level/pointers.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wptr_q] <= stage_w;
        end
    end

    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign level        = level_q;
    assign wr_overflow  = wr_ovf_q;
    assign rd_underflow = rd_unf_q;

endmodule

// File: tb/tb_core_lbuf.sv
// Bench for core_lbuf: a packing/FIFO model feeds a scoreboard of expected read words
// that a negedge monitor pops whenever the buffer presents rvalid.
module tb_core_lbuf;

    localparam int WRW   = 64;
    localparam int RATIO = 4;
    localparam int DEPTH = 8;
    localparam int RDW   = WRW * RATIO;

    logic           clk = 1'b0;
    logic           rst, clear, wen, ren;
    logic [WRW-1:0] wdata;
    logic [RDW-1:0] rdata;
    logic           rvalid, empty, full, wr_overflow, rd_underflow;
    logic [3:0]     level;

    int checks = 0;
    int errors = 0;

    logic [RDW-1:0] sb_q[$];
    logic [RDW-1:0] m_words[$];
    logic [RDW-1:0] m_stage;
    int             m_sub;

    core_lbuf #(.WR_WIDTH(WRW), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .empty(empty), .full(full), .level(level),
        .wr_overflow(wr_overflow), .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout reached, simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            logic [RDW-1:0] exp;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_rvalid got rdata=%h required no read", rdata);
            end else begin
                exp = sb_q.pop_front();
                if (rdata !== exp) begin
                    errors++;
                    $display("FAIL sb_rdata got %h required %h", rdata, exp);
                end
            end
        end
    end

    task automatic step(input logic w, input logic [WRW-1:0] d, input logic r, input logic c);
        int sz;
        wen = w; wdata = d; ren = r; clear = c;
        @(posedge clk);
        sz = m_words.size();
        if (c) begin
            m_words.delete();
            m_sub   = 0;
            m_stage = '0;
        end else begin
            if (r && sz != 0) sb_q.push_back(m_words.pop_front());
            if (w && sz != DEPTH) begin
                m_stage[m_sub*WRW +: WRW] = d;
                if (m_sub == RATIO - 1) begin
                    m_words.push_back(m_stage);
                    m_sub = 0;
                end else begin
                    m_sub++;
                end
            end
        end
        #1;
        wen = 1'b0; ren = 1'b0; clear = 1'b0; wdata = '0;
    endtask

    task automatic do_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending reads required 0", sb_q.size());
        end
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        m_words.delete();
        m_sub   = 0;
        m_stage = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
        do_reset();
        checks++;
        if ({empty, full, level, rvalid, wr_overflow, rd_underflow} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags got e=%b f=%b l=%0d rv=%b ov=%b un=%b required e=1 f=0 l=0 rv=0 ov=0 un=0",
                     empty, full, level, rvalid, wr_overflow, rd_underflow);
        end
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h required 0", rdata);
        end
    endtask

    task automatic test_pack_order();
        logic [RDW-1:0] want;
        want = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        step(1, 64'h1111111111111111, 0, 0);
        step(1, 64'h2222222222222222, 0, 0);
        step(1, 64'h3333333333333333, 0, 0);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL pack_partial_empty got %b required 1", empty);
        end
        step(1, 64'h4444444444444444, 0, 0);
        checks++;
        if (empty !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL pack_word_ready got empty=%b level=%0d required empty=0 level=1", empty, level);
        end
        step(0, '0, 1, 0);
        checks++;
        if (rvalid !== 1'b1 || rdata !== want) begin
            errors++;
            $display("FAIL pack_rdata got rv=%b rdata=%h required rv=1 rdata=%h", rvalid, rdata, want);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL pack_empty_after got %b required 1", empty);
        end
        step(0, '0, 0, 0);
        checks++;
        if (rvalid !== 1'b0 || rdata !== want) begin
            errors++;
            $display("FAIL pack_hold got rv=%b rdata=%h required rv=0 rdata=%h", rvalid, rdata, want);
        end
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 0; i < 32; i++) step(1, {32'(i), 32'hA5A50000 | 32'(i)}, 0, 0);
        checks++;
        if (full !== 1'b1 || level !== 4'd8 || wr_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_level got full=%b level=%0d ov=%b required full=1 level=8 ov=0", full, level, wr_overflow);
        end
        step(1, 64'hDEADDEADDEADDEAD, 0, 0);
        checks++;
        if (wr_overflow !== 1'b1 || level !== 4'd8) begin
            errors++;
            $display("FAIL overflow got ov=%b level=%0d required ov=1 level=8", wr_overflow, level);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 1, 0);
            checks++;
            if (full !== 1'b0 || level !== 4'(7 - i) || empty !== (i == 7)) begin
                errors++;
                $display("FAIL drain_flags[%0d] got full=%b level=%0d empty=%b required full=0 level=%0d empty=%b",
                         i, full, level, empty, 7 - i, i == 7);
            end
        end
        step(0, '0, 0, 0);
    endtask

    task automatic test_underflow_partial();
        do_reset();
        step(1, 64'hAAAA0000AAAA0000, 0, 0);
        step(1, 64'hBBBB1111BBBB1111, 0, 0);
        step(1, 64'hCCCC2222CCCC2222, 0, 0);
        step(0, '0, 1, 0);
        checks++;
        if (rvalid !== 1'b0 || rd_underflow !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow got rv=%b un=%b empty=%b required rv=0 un=1 empty=1", rvalid, rd_underflow, empty);
        end
        step(1, 64'hDDDD3333DDDD3333, 0, 0);
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL partial_complete got level=%0d required 1", level);
        end
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 32; i++) step(1, 64'h5000 + 64'(i), 0, 0);
        step(1, 64'hFFFF0000FFFF0000, 1, 0);
        checks++;
        if (level !== 4'd7 || wr_overflow !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL simul_full got level=%0d ov=%b full=%b required level=7 ov=1 full=0", level, wr_overflow, full);
        end
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 64'h7000 + 64'(i), 0, 0);
        step(1, 64'h700F, 1, 0);
        checks++;
        if (level !== 4'd3) begin
            errors++;
            $display("FAIL simul_push_pop got level=%0d required 3", level);
        end
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
    endtask

    task automatic test_clear();
        logic [RDW-1:0] want;
        do_reset();
        step(0, '0, 1, 0);
        for (int i = 0; i < 22; i++) step(1, 64'h9000 + 64'(i), 0, 0);
        checks++;
        if (level !== 4'd5 || rd_underflow !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup got level=%0d un=%b required level=5 un=1", level, rd_underflow);
        end
        step(1, 64'hBADBADBADBADBAD0, 1, 1);
        checks++;
        if ({level, empty, full, wr_overflow, rd_underflow, rvalid} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_state got l=%0d e=%b f=%b ov=%b un=%b rv=%b required l=0 e=1 f=0 ov=0 un=0 rv=0",
                     level, empty, full, wr_overflow, rd_underflow, rvalid);
        end
        want = {64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C, 64'h0B0B0B0B0B0B0B0B, 64'h0A0A0A0A0A0A0A0A};
        step(1, 64'h0A0A0A0A0A0A0A0A, 0, 0);
        step(1, 64'h0B0B0B0B0B0B0B0B, 0, 0);
        step(1, 64'h0C0C0C0C0C0C0C0C, 0, 0);
        step(1, 64'h0D0D0D0D0D0D0D0D, 0, 0);
        step(0, '0, 1, 0);
        checks++;
        if (rvalid !== 1'b1 || rdata !== want) begin
            errors++;
            $display("FAIL clear_fresh got rv=%b rdata=%h required rv=1 rdata=%h", rvalid, rdata, want);
        end
        step(0, '0, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) == 0, 0);
            checks++;
            if (level !== 4'(m_words.size()) || empty !== (m_words.size() == 0) ||
                full !== (m_words.size() == DEPTH)) begin
                errors++;
                $display("FAIL b2b_flags[%0d] got level=%0d empty=%b full=%b required level=%0d",
                         i, level, empty, full, m_words.size());
            end
        end
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
    endtask

    initial begin
        m_sub   = 0;
        m_stage = '0;
        test_reset();
        test_pack_order();
        test_full_overflow();
        test_underflow_partial();
        test_simultaneous();
        test_clear();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_final got %0d pending reads required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
